llc_req_in_fifo: RTL

LLC_REQ_IN_FIFO -- requirements
Module: llc_req_in_fifo

---
 rtl/llc_req_in_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/llc_req_in_fifo.sv
// LLC request input FIFO: buffers NoC requests ahead of the LLC input decoder.
// Optional macro LLC_REQ_FIFO_BYPASS_EN adds a zero-latency path from the NoC
// inputs to the decoder outputs while the FIFO is empty.

package llc_req_in_fifo_pkg;
    localparam int unsigned LINE_ADDR_W = 26;
    typedef logic [LINE_ADDR_W-1:0] line_addr_t;
endpackage

module llc_req_in_fifo
    import llc_req_in_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         llc_req_in_valid,
    output logic                         llc_req_in_ready,
    input  line_addr_t                   llc_req_in_addr,
    input  logic [DATA_W-1:0]            llc_req_in_data,
    output logic                         llc_req_in_valid_int,
    input  logic                         llc_req_in_ready_int,
    output line_addr_t                   req_in_addr,
    output logic [DATA_W-1:0]            req_in_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         fifo_full,
    output logic                         fifo_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = LINE_ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic [ENT_W-1:0] head_q,   head_d;

    logic             push;
    logic             pop;
    logic             bypass_take;
    logic [ENT_W-1:0] in_entry;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_entry         = {llc_req_in_addr, llc_req_in_data};
    assign llc_req_in_ready = !full_q && !rst;
    assign fifo_count       = count_q;
    assign fifo_full        = full_q;
    assign fifo_empty       = empty_q;

`ifdef LLC_REQ_FIFO_BYPASS_EN
    logic bypass_vis;

    // Empty FIFO with an incoming request: present it to the decoder directly.
    always_comb begin
        bypass_vis           = empty_q && llc_req_in_valid && !rst;
        bypass_take          = bypass_vis && llc_req_in_ready_int;
        llc_req_in_valid_int = !empty_q || bypass_vis;
        req_in_addr          = bypass_vis ? llc_req_in_addr : head_q[ENT_W-1:DATA_W];
        req_in_data          = bypass_vis ? llc_req_in_data : head_q[DATA_W-1:0];
    end
`else
    // Head outputs come only from registered state.
    always_comb begin
        bypass_take          = 1'b0;
        llc_req_in_valid_int = !empty_q;
        req_in_addr          = head_q[ENT_W-1:DATA_W];
        req_in_data          = head_q[DATA_W-1:0];
    end
`endif

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        push     = llc_req_in_valid && llc_req_in_ready && !bypass_take;
        pop      = !empty_q && llc_req_in_ready_int;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);

        // The new head is the entry being written now if it lands at rd_ptr_d.
        if (!empty_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_entry;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Control state and head register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_entry;
        end
    end

endmodule
